// File: rtl/dmi_arbiter.sv
// Round-robin arbiter sharing one Debug Module DMI port among N_REQ transports.
// One transaction in flight; a stalled DM is timed out and its late reply dropped.
module dmi_arbiter #(
   parameter int N_REQ   = 2,
   parameter int REQ_W   = 41,
   parameter int RESP_W  = 34,
   parameter int TIMEOUT = 1024,
   localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1,
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
   input  logic                     CLK_I,
   input  logic                     RST_I,
   input  logic [N_REQ-1:0]         REQ_VALID_I,
   output logic [N_REQ-1:0]         REQ_READY_O,
   input  logic [N_REQ*REQ_W-1:0]   REQ_DATA_I,
   output logic [N_REQ-1:0]         RESP_VALID_O,
   input  logic [N_REQ-1:0]         RESP_READY_I,
   output logic [RESP_W-1:0]        RESP_DATA_O,
   output logic                     DMI_REQ_VALID_O,
   input  logic                     DMI_REQ_READY_I,
   output logic [REQ_W-1:0]         DMI_REQ_O,
   input  logic                     DMI_RESP_VALID_I,
   output logic                     DMI_RESP_READY_O,
   input  logic [RESP_W-1:0]        DMI_RESP_I,
   output logic [OW-1:0]            OWNER_O,
   output logic                     BUSY_O,
   output logic                     TIMEOUT_O
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP, DELIVER} state_t;

   state_t            state;
   logic [OW-1:0]     owner;
   logic [REQ_W-1:0]  req_q;
   logic [RESP_W-1:0] resp_q;
   logic [CW-1:0]     cnt;
   logic              drop_pending;
   logic              timeout_q;
   logic              any_vld;
   logic              grant;
   logic [OW-1:0]     grant_idx;
   logic [OW-1:0]     idx;

   // Scan downward so the last hit is the first valid after the owner.
   always_comb begin
      any_vld   = 1'b0;
      grant_idx = '0;
      idx       = '0;
      for (int k = N_REQ; k >= 1; k--) begin
         idx = OW'((int'(owner) + k) % N_REQ);
         if (REQ_VALID_I[idx]) begin
            any_vld   = 1'b1;
            grant_idx = idx;
         end
      end
   end

   assign grant = (state == IDLE) && !drop_pending && any_vld;

   always_comb begin
      REQ_READY_O  = '0;
      RESP_VALID_O = '0;
      if (grant)
         REQ_READY_O[grant_idx] = 1'b1;
      if (state == DELIVER)
         RESP_VALID_O[owner] = 1'b1;
   end

   assign DMI_REQ_VALID_O  = (state == ISSUE);
   assign DMI_REQ_O        = req_q;
   assign DMI_RESP_READY_O = (state == WAIT_RESP) || drop_pending;
   assign RESP_DATA_O      = resp_q;
   assign OWNER_O          = owner;
   assign BUSY_O           = (state != IDLE);
   assign TIMEOUT_O        = timeout_q;

   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         state        <= IDLE;
         owner        <= OW'(N_REQ - 1);
         req_q        <= '0;
         resp_q       <= '0;
         cnt          <= '0;
         drop_pending <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         timeout_q <= 1'b0;
         if (drop_pending && DMI_RESP_VALID_I)
            drop_pending <= 1'b0;
         unique case (state)
            IDLE: begin
               if (grant) begin
                  req_q <= REQ_DATA_I[int'(grant_idx)*REQ_W +: REQ_W];
                  owner <= grant_idx;
                  state <= ISSUE;
               end
            end
            ISSUE: begin
               if (DMI_REQ_READY_I) begin
                  cnt   <= '0;
                  state <= WAIT_RESP;
               end
            end
            WAIT_RESP: begin
               if (DMI_RESP_VALID_I) begin
                  resp_q <= DMI_RESP_I;
                  state  <= DELIVER;
               end else if (TIMEOUT != 0 && int'(cnt) == TIMEOUT - 1) begin
                  // Answer with a DTM error; the DM's eventual reply gets swallowed.
                  resp_q       <= {{(RESP_W-2){1'b0}}, 2'b10};
                  drop_pending <= 1'b1;
                  timeout_q    <= 1'b1;
                  state        <= DELIVER;
               end else if (cnt != '1) begin
                  cnt <= cnt + 1'b1;
               end
            end
            DELIVER: begin
               if (RESP_READY_I[owner])
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmi_arbiter.sv
// Randomized bench for dmi_arbiter checked cycle by cycle against a
// transaction-level model of grants, DM traffic, timeouts and drops.
module tb_dmi_arbiter;
   localparam int N   = 2;
   localparam int RW  = 41;
   localparam int SW  = 34;
   localparam int TMO = 8;
   localparam int OW  = 1;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_valid, req_ready, resp_valid, resp_ready;
   logic [N*RW-1:0] req_data;
   logic [SW-1:0]   resp_data, dmi_resp;
   logic [RW-1:0]   dmi_req;
   logic            dmi_req_valid, dmi_req_ready;
   logic            dmi_resp_valid, dmi_resp_ready;
   logic [OW-1:0]   owner;
   logic            busy, tmo;

   always #5 clk = ~clk;

   dmi_arbiter #(.N_REQ(N), .REQ_W(RW), .RESP_W(SW), .TIMEOUT(TMO)) dut (
      .CLK_I(clk), .RST_I(rst),
      .REQ_VALID_I(req_valid), .REQ_READY_O(req_ready),
      .REQ_DATA_I(req_data),
      .RESP_VALID_O(resp_valid), .RESP_READY_I(resp_ready),
      .RESP_DATA_O(resp_data),
      .DMI_REQ_VALID_O(dmi_req_valid), .DMI_REQ_READY_I(dmi_req_ready),
      .DMI_REQ_O(dmi_req),
      .DMI_RESP_VALID_I(dmi_resp_valid), .DMI_RESP_READY_O(dmi_resp_ready),
      .DMI_RESP_I(dmi_resp),
      .OWNER_O(owner), .BUSY_O(busy), .TIMEOUT_O(tmo)
   );

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;

   // transaction model
   bit            m_act, m_sent, m_have, m_drop, m_tmo;
   int            m_own, m_wait;
   logic [RW-1:0] m_req;
   logic [SW-1:0] m_resp;
   int            done_cnt = 0;
   int            glog[$];
   int            gcyc[$];
   int            acc_cyc = -1, tmo_cyc = -1, drop_cyc = -1;

   // requesters and DM
   bit            r_pend[N];
   logic [RW-1:0] r_pay[N];
   bit            dm_pend;
   int            dm_dly;
   logic [RW-1:0] dm_req;

   int k_new, k_hold, k_rr, k_dr, k_long, force_dly;

   task automatic chk(string tag, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   function automatic logic [SW-1:0] dm_fn(logic [RW-1:0] r);
      return {r[33:2] ^ 32'h5A5A_0000 ^ {25'b0, r[40:34]}, r[1:0] ^ 2'b01};
   endfunction

   function automatic int exp_win(logic [N-1:0] v, int last);
      for (int k = 1; k <= N; k++)
         if (v[(last + k) % N]) return (last + k) % N;
      return -1;
   endfunction

   task automatic model_reset();
      m_act = 0; m_sent = 0; m_have = 0; m_drop = 0; m_tmo = 0;
      m_own = N - 1; m_wait = 0;
      dm_pend = 0; dm_dly = 0; dm_req = '0;
   endtask

   task automatic drive();
      logic [63:0] t;
      for (int i = 0; i < N; i++) begin
         if (!r_pend[i] && $urandom_range(99) < k_new) begin
            t = {$urandom(), $urandom()};
            r_pend[i] = 1;
            r_pay[i]  = t[RW-1:0];
         end
         req_valid[i] = r_pend[i] && ($urandom_range(99) < k_hold);
         req_data[i*RW +: RW] = r_pay[i];
         resp_ready[i] = ($urandom_range(99) < k_rr);
      end
      dmi_req_ready  = ($urandom_range(99) < k_dr);
      dmi_resp_valid = dm_pend && dm_dly == 0;
      dmi_resp       = dm_fn(dm_req);
   endtask

   task automatic step_check();
      int w;
      logic [N-1:0] er, ev;
      cyc++;
      w  = (!m_act && !m_drop) ? exp_win(req_valid, m_own) : -1;
      er = '0;
      if (w >= 0) er[w] = 1'b1;
      ev = '0;
      if (m_act && m_have) ev[m_own] = 1'b1;
      chk("req_ready", 64'(req_ready), 64'(er));
      chk("dmi_req_valid", 64'(dmi_req_valid), 64'(m_act && !m_sent));
      if (m_act && !m_sent) chk("dmi_req", 64'(dmi_req), 64'(m_req));
      chk("resp_valid", 64'(resp_valid), 64'(ev));
      if (m_act && m_have) chk("resp_data", 64'(resp_data), 64'(m_resp));
      chk("dmi_resp_ready", 64'(dmi_resp_ready),
          64'((m_act && m_sent && !m_have) || m_drop));
      chk("owner", 64'(owner), 64'(m_own));
      chk("busy", 64'(busy), 64'(m_act));
      chk("timeout", 64'(tmo), 64'(m_tmo));
      if (tmo) tmo_cyc = cyc;
      m_tmo = 0;
      if (dm_pend) begin
         if (dmi_resp_valid && dmi_resp_ready) dm_pend = 0;
         else if (dm_dly > 0) dm_dly--;
      end
      if (m_drop && dmi_resp_valid) begin
         m_drop = 0;
         drop_cyc = cyc;
      end
      if (w >= 0) begin
         m_act = 1; m_sent = 0; m_have = 0;
         m_own = w; m_req = r_pay[w]; r_pend[w] = 0;
         glog.push_back(w);
         gcyc.push_back(cyc);
      end else if (m_act && !m_sent && dmi_req_ready) begin
         m_sent = 1; m_wait = 0; acc_cyc = cyc;
         dm_pend = 1; dm_req = m_req;
         if (force_dly >= 0) dm_dly = force_dly;
         else if ($urandom_range(99) < k_long) dm_dly = $urandom_range(14, 9);
         else dm_dly = $urandom_range(3);
      end else if (m_act && m_sent && !m_have) begin
         if (dmi_resp_valid) begin
            m_have = 1; m_resp = dm_fn(m_req);
         end else if (m_wait + 1 == TMO) begin
            m_have = 1; m_resp = {32'h0, 2'b10};
            m_drop = 1; m_tmo = 1;
         end else begin
            m_wait++;
         end
      end else if (m_act && m_have && resp_ready[m_own]) begin
         m_act = 0;
         done_cnt++;
      end
   endtask

   task automatic run(int n);
      repeat (n) begin
         @(posedge clk); #1;
         drive();
         @(negedge clk);
         step_check();
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1; req_valid = '0; resp_ready = '0;
      dmi_req_ready = 0; dmi_resp_valid = 0;
      @(posedge clk); #1;
      rst = 0;
      model_reset();
      @(negedge clk);
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_resp_valid", 64'(resp_valid), 64'd0);
      chk("rst_dmi_req_valid", 64'(dmi_req_valid), 64'd0);
      chk("rst_dmi_resp_ready", 64'(dmi_resp_ready), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_owner", 64'(owner), 64'(N - 1));
      chk("rst_timeout", 64'(tmo), 64'd0);
      chk("rst_dmi_req", 64'(dmi_req), 64'd0);
   endtask

   task automatic knobs(int nw, int hd, int rr, int dr, int lg, int fd);
      k_new = nw; k_hold = hd; k_rr = rr; k_dr = dr; k_long = lg; force_dly = fd;
   endtask

   initial begin
      int d0;
      rst = 1; req_valid = '0; req_data = '0; resp_ready = '0;
      dmi_req_ready = 0; dmi_resp_valid = 0; dmi_resp = '0;
      for (int i = 0; i < N; i++) begin r_pend[i] = 0; r_pay[i] = '0; end
      model_reset();
      knobs(0, 100, 100, 100, 0, 0);
      do_reset();

      // single write from requester 0
      r_pend[0] = 1;
      r_pay[0]  = {7'h10, 32'hDEADBEEF, 2'b10};
      run(8);
      chk("single_grants", 64'(glog.size()), 64'd1);
      chk("single_done", 64'(done_cnt), 64'd1);
      chk("single_owner", 64'(owner), 64'd0);

      // contention: alternating grants
      do_reset();
      glog.delete(); gcyc.delete();
      knobs(100, 100, 100, 100, 0, 0);
      for (int i = 0; i < 200 && glog.size() < 4; i++) run(1);
      chk("contention_grants", 64'(glog.size() >= 4), 64'd1);
      for (int i = 0; i < 4; i++)
         if (i < glog.size()) chk("contention_order", 64'(glog[i]), 64'(i % 2));

      // backpressure on both DM request and requester response
      knobs(100, 100, 0, 0, 0, 0);
      run(5);
      k_dr = 100;
      for (int i = 0; i < 50 && !(m_act && m_have); i++) run(1);
      chk("bp_resp_ready", 64'(m_act && m_have), 64'd1);
      d0 = done_cnt;
      run(3);
      chk("bp_held", 64'(done_cnt), 64'(d0));
      k_rr = 100;
      run(4);

      // timeout, then the late reply is dropped before requester 1 is served
      do_reset();
      glog.delete(); gcyc.delete();
      tmo_cyc = -1; drop_cyc = -1;
      knobs(100, 100, 100, 100, 0, 20);
      for (int i = 0; i < 100 && tmo_cyc < 0; i++) run(1);
      chk("tmo_fired", 64'(tmo_cyc >= 0), 64'd1);
      chk("tmo_latency", 64'(tmo_cyc - (acc_cyc + 1)), 64'(TMO));
      force_dly = 0;
      for (int i = 0; i < 100 && glog.size() < 2; i++) run(1);
      chk("post_drop_grant", 64'(glog.size() >= 2), 64'd1);
      if (glog.size() >= 2) begin
         chk("post_drop_idx", 64'(glog[1]), 64'd1);
         chk("grant_after_drop", 64'(drop_cyc >= 0 && gcyc[1] > drop_cyc), 64'd1);
      end
      run(6);

      // reset while waiting on the DM
      knobs(100, 100, 100, 100, 0, 20);
      for (int i = 0; i < 50 && !(m_act && m_sent && !m_have); i++) run(1);
      chk("mid_waiting", 64'(m_act && m_sent && !m_have), 64'd1);
      run(2);
      do_reset();
      knobs(100, 100, 100, 100, 0, 1);
      d0 = done_cnt;
      for (int i = 0; i < 50 && done_cnt == d0; i++) run(1);
      chk("after_reset_done", 64'(done_cnt > d0), 64'd1);

      // random soak
      knobs(40, 70, 60, 60, 20, -1);
      run(3000);
      chk("soak_progress", 64'(done_cnt > d0 + 20), 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/dmi_arbiter.md
Name: dmi_arbiter

Overview:
- Shares the single Debug Module DMI ready/valid port between N_REQ debug transports, e.g. the UART DMI adapter and a JTAG DTM.
- Grants one requester at a time with round-robin fairness and forwards its request to the DM.
- Routes the DM's single response back to the granted requester only.
- A response timeout frees the bus if the DM stalls.

Parameters:
- N_REQ, 2: number of requesters; must be >= 2.
- REQ_W, 41: DMI request width {addr[6:0], data[31:0], op[1:0]}, op in bits [1:0].
- RESP_W, 34: DMI response width {data[31:0], resp[1:0]}, resp in bits [1:0].
- TIMEOUT, 1024: cycles to wait for a DM response; 0 disables the timeout.

Ports:
- CLK_I  in  1  clock
- RST_I  in  1  synchronous reset, active-high
- REQ_VALID_I  in  N_REQ  per-requester request valid
- REQ_READY_O  out  N_REQ  per-requester request ready
- REQ_DATA_I  in  N_REQ x REQ_W  per-requester request payload
- RESP_VALID_O  out  N_REQ  per-requester response valid
- RESP_READY_I  in  N_REQ  per-requester response ready
- RESP_DATA_O  out  RESP_W  response payload, shared by all requesters; qualified by RESP_VALID_O
- DMI_REQ_VALID_O  out  1  request valid toward the DM
- DMI_REQ_READY_I  in  1  DM accepts request
- DMI_REQ_O  out  REQ_W  request payload toward the DM
- DMI_RESP_VALID_I  in  1  DM response valid
- DMI_RESP_READY_O  out  1  arbiter accepts response
- DMI_RESP_I  in  RESP_W  DM response payload
- OWNER_O  out  max(1,$clog2(N_REQ))  index of the current or last granted requester
- BUSY_O  out  1  high in any state other than IDLE
- TIMEOUT_O  out  1  one-cycle pulse when a timeout fires

Behaviour:
- FSM states: IDLE, ISSUE, WAIT_RESP, DELIVER.
- Reset, synchronous and taking effect from any state: state=IDLE; all valid/ready outputs 0; request and response registers 0; OWNER_O=N_REQ-1, so requester 0 wins first; drop_pending=0; timeout counter 0; TIMEOUT_O=0.
- IDLE:
  - When drop_pending=0 and any REQ_VALID_I is high, pick the winner by round-robin: scan from OWNER_O+1 upward, wrapping.
  - REQ_READY_O[winner] is combinationally high in that cycle; all other REQ_READY_O stay 0.
  - On handshake: latch REQ_DATA_I[winner] into the request register, set OWNER_O=winner, go to ISSUE.
- ISSUE:
  - DMI_REQ_VALID_O=1 and DMI_REQ_O holds the latched request, stable until DMI_REQ_READY_I.
  - On ready: go to WAIT_RESP and clear the counter.
  - Requests of every op, including NOP, are forwarded; the DM returns exactly one response per accepted request.
- WAIT_RESP:
  - DMI_RESP_READY_O=1.
  - On DMI_RESP_VALID_I: latch DMI_RESP_I and go to DELIVER.
  - Otherwise increment the counter.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT-1 without a response: latch {data=0, resp=2'b10 (DTM error)}, set drop_pending=1, pulse TIMEOUT_O, go to DELIVER.
- DELIVER:
  - RESP_VALID_O[OWNER_O]=1 and RESP_DATA_O holds the latched response.
  - On RESP_READY_I[OWNER_O]: go to IDLE.
- drop_pending:
  - While set, DMI_RESP_READY_O=1 in IDLE and DELIVER.
  - The next DMI_RESP_VALID_I is consumed, discarded, and clears drop_pending.
  - No new grant is issued while drop_pending=1.
  - Only reset clears drop_pending without a DM response.
- Latency:
  - Request handshake at cycle t gives DMI_REQ_VALID_O at t+1.
  - DM response captured at cycle u gives RESP_VALID_O at u+1.
  - Requester response handshake at cycle v returns to IDLE at v+1, so the earliest next grant is at v+1.
- Only one transaction is outstanding; other requesters see REQ_READY_O=0 until the arbiter returns to IDLE.
- RESP_VALID_O is never high for a non-owner.
- A requester dropping REQ_VALID_I before its handshake is not granted; no latching occurs.
- Counter width is $clog2(TIMEOUT+1); it saturates and never wraps.

Test Plan:
- Single request: req0 write {addr=0x10, data=0xDEADBEEF, op=2} with DM ready/resp immediate -> DMI_REQ_O matches the request one cycle after the handshake; RESP_VALID_O[0] one cycle after the DM response; OWNER_O=0.
- Contention: req0 and req1 both valid from reset, 4 back-to-back transactions -> grant order 0,1,0,1; RESP_VALID_O[1] never high during requester 0's transactions.
- Backpressure: DMI_REQ_READY_I held low 5 cycles, then RESP_READY_I[owner] held low 3 cycles -> DMI_REQ_O, RESP_DATA_O and OWNER_O stable; no second grant.
- Timeout with TIMEOUT=8: DM never responds -> TIMEOUT_O pulses 8 cycles after entering WAIT_RESP; requester gets resp=2, data=0. A late DM response (data 0x1234) is dropped; a pending req1 is granted only after the drop.
- Reset mid-transaction: assert RST_I in WAIT_RESP -> next cycle all valid/ready outputs 0, BUSY_O=0, OWNER_O=N_REQ-1; a subsequent request completes normally.
